// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one main-memory block port between the
// instruction-side cache (port 0) and the data-side cache (port 1).
// Each grant holds mem_rw/mem_addr/mem_wdata stable for MEM_LAT cycles,
// captures the read block on the last busy cycle, then pulses doneX.
// Optional build macro ARB_RR_EN: round-robin arbitration on conflicts.
// Without it, port 1 has fixed priority on conflicts.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 128,
  parameter int MEM_LAT = 4     // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              mem_rw_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              pick1;   // 1 when port 1 wins the IDLE-cycle arbitration

`ifdef ARB_RR_EN
  logic last, last_nxt;       // most recently granted port

  // Round-robin: on a conflict the port that was not granted last wins.
  always_comb begin
    pick1 = req1 & (~req0 | ~last);
  end
`else
  // Fixed priority: the data side always wins a conflict.
  always_comb begin
    pick1 = req1;
  end
`endif

  // Next-state and next-output logic; every register is updated from here.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_nxt     = state;
    cnt_nxt       = cnt;
    gnt0_nxt      = gnt0;
    gnt1_nxt      = gnt1;
    done0_nxt     = 1'b0;
    done1_nxt     = 1'b0;
    rdata_nxt     = rdata;
    mem_rw_nxt    = mem_rw;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
`ifdef ARB_RR_EN
    last_nxt      = last;
`endif
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt     = BUSY;
          cnt_nxt       = CNT_INIT;
          gnt0_nxt      = ~pick1;
          gnt1_nxt      = pick1;
          mem_rw_nxt    = pick1 ? rw1    : rw0;
          mem_addr_nxt  = pick1 ? addr1  : addr0;
          mem_wdata_nxt = pick1 ? wdata1 : wdata0;
`ifdef ARB_RR_EN
          last_nxt      = pick1;
`endif
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          if (!mem_rw) rdata_nxt = mem_rdata;
          mem_rw_nxt = 1'b0;
          done0_nxt  = gnt0;
          done1_nxt  = gnt1;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      done0     <= done0_nxt;
      done1     <= done1_nxt;
      rdata     <= rdata_nxt;
      mem_rw    <= mem_rw_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
`ifdef ARB_RR_EN
      last      <= last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bench for cache_mem_arbiter with a
// latency-honouring memory model and an in-order completion scoreboard.
module tb_cache_mem_arbiter;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 128;
  localparam int MEM_LAT = 4;
`ifdef ARB_RR_EN
  localparam bit FIRST = 1'b0;
`else
  localparam bit FIRST = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, done0, done1, mem_rw;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  // Second instance exercising the MEM_LAT=1 boundary.
  logic              l_req = 1'b0;
  logic              l_gnt0, l_gnt1, l_done0, l_done1, l_mem_rw;
  logic [DATA_W-1:0] l_rdata, l_mem_wdata;
  logic [ADDR_W-1:0] l_mem_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int done0_cnt = 0;
  int done1_cnt = 0;

  typedef struct {
    bit                port;
    bit                is_read;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t              sb[$];
  logic [DATA_W-1:0] model_rdata = '0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req0(l_req), .req1(1'b0), .rw0(1'b0), .rw1(1'b0),
    .addr0(10'h005), .addr1('0), .wdata0('0), .wdata1('0),
    .gnt0(l_gnt0), .gnt1(l_gnt1), .done0(l_done0), .done1(l_done1), .rdata(l_rdata),
    .mem_rw(l_mem_rw), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
    .mem_rdata(128'h00C0_FFEE)
  );

  // Memory model: data only valid on the MEM_LAT-th busy cycle, garbage before.
  logic [DATA_W-1:0] mem [0:1023];
  int                age;
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) age <= 0;
    else if ((gnt0 || gnt1) && !(done0 || done1)) age <= age + 1;
    else age <= 0;
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_rw) mem[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = (age == MEM_LAT - 1) ? mem[mem_addr] : {4{32'hBAD0_BAD0}};

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding transaction.
  always @(negedge clk) begin
    if (rst_n && (done0 || done1)) begin
      exp_t e;
      if (done0) done0_cnt++;
      if (done1) done1_cnt++;
      check("sb_nonempty", 128'(sb.size() > 0), 128'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.is_read) model_rdata = e.data;
        check("done_port", {127'b0, done1}, {127'b0, e.port});
        check("done_single", {127'b0, done0 & done1}, 128'd0);
        check("rdata", rdata, model_rdata);
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue(input bit p, input bit rw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rd_exp);
    if (p) begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
    sb.push_back('{port: p, is_read: !rw, data: rd_exp});
  endtask

  // Wait (bounded) for the port's done pulse; check cycles taken, then drop req.
  task automatic wait_done(input bit p, input int exp_n, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? done1 : done0) && n < 30);
    check(tag, 128'(n), 128'(exp_n));
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},   {126'b0, gnt1, gnt0}, 128'd0);
    check({tag, "_done"},  {126'b0, done1, done0}, 128'd0);
    check({tag, "_memrw"}, {127'b0, mem_rw}, 128'd0);
    check({tag, "_addr"},  128'(mem_addr), 128'd0);
    check({tag, "_wdata"}, mem_wdata, 128'd0);
    check({tag, "_rdata"}, rdata, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset state.
    #2 check_idle_outputs("reset");
    preload(10'h0A0, 128'h1111_2222_3333_4444);
    preload(10'h055, 128'h5555_AAAA);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read on port 0.
    issue(1'b0, 1'b0, 10'h0A0, '0, 128'h1111_2222_3333_4444);
    @(negedge clk);
    check("rd_gnt", {126'b0, gnt1, gnt0}, 128'b01);
    check("rd_memrw", {127'b0, mem_rw}, 128'd0);
    check("rd_addr", 128'(mem_addr), 128'h0A0);
    wait_done(1'b0, MEM_LAT, "rd_lat");
    check("rd_memrw_done", {127'b0, mem_rw}, 128'd0);
    @(negedge clk);

    // Single write on port 1, then read it back on port 0.
    issue(1'b1, 1'b1, 10'h3F0, 128'hDEAD_BEEF, '0);
    for (int i = 1; i <= MEM_LAT; i++) begin
      @(negedge clk);
      check("wr_gnt", {126'b0, gnt1, gnt0}, 128'b10);
      check("wr_memrw", {127'b0, mem_rw}, 128'd1);
      check("wr_addr", 128'(mem_addr), 128'h3F0);
      check("wr_wdata", mem_wdata, 128'hDEAD_BEEF);
      if (i == 2) wdata1 = 128'h0BAD;
    end
    wait_done(1'b1, 1, "wr_lat");
    check("wr_memrw_done", {127'b0, mem_rw}, 128'd0);
    @(negedge clk);
    issue(1'b0, 1'b0, 10'h3F0, '0, 128'hDEAD_BEEF);
    wait_done(1'b0, MEM_LAT + 1, "rdback_lat");
    @(negedge clk);

    // Conflicts: both requests rise together, twice.
    for (int r = 0; r < 2; r++) begin
      issue(FIRST, 1'b0, FIRST ? 10'h3F0 : 10'h0A0, '0,
            FIRST ? 128'hDEAD_BEEF : 128'h1111_2222_3333_4444);
      issue(!FIRST, 1'b0, FIRST ? 10'h0A0 : 10'h3F0, '0,
            FIRST ? 128'h1111_2222_3333_4444 : 128'hDEAD_BEEF);
      @(negedge clk);
      check("cf_first_gnt", {126'b0, gnt1, gnt0}, FIRST ? 128'b10 : 128'b01);
      wait_done(FIRST, MEM_LAT, "cf_first_lat");
      @(negedge clk);
      check("cf_gap_gnt", {126'b0, gnt1, gnt0}, 128'd0);
      @(negedge clk);
      check("cf_second_gnt", {126'b0, gnt1, gnt0}, FIRST ? 128'b01 : 128'b10);
      wait_done(!FIRST, MEM_LAT, "cf_second_lat");
      @(negedge clk);
    end

    // Stability: addr change and req drop during BUSY are ignored.
    d0 = done0_cnt;
    issue(1'b0, 1'b0, 10'h055, '0, 128'h5555_AAAA);
    @(negedge clk);
    @(negedge clk);
    check("st_addr_a", 128'(mem_addr), 128'h055);
    addr0 = 10'h1FF;
    req0  = 1'b0;
    @(negedge clk);
    check("st_addr_b", 128'(mem_addr), 128'h055);
    wait_done(1'b0, MEM_LAT - 2, "st_lat");
    @(negedge clk);
    check("st_done_clear", {127'b0, done0}, 128'd0);
    @(negedge clk);
    check("st_no_regrant", {127'b0, gnt0}, 128'd0);
    check("st_done_count", 128'(done0_cnt - d0), 128'd1);

    // Reset in the middle of a read: no done, then a fresh grant.
    d0 = done0_cnt;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 10'h0A0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("mid_rst");
    sb.delete();
    model_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_done", {127'b0, done0}, 128'd0);
    end
    check("mid_rst_no_done", 128'(done0_cnt - d0), 128'd0);
    rst_n = 1'b1;
    sb.push_back('{port: 1'b0, is_read: 1'b1, data: 128'h1111_2222_3333_4444});
    @(negedge clk);
    check("post_rst_gnt", {127'b0, gnt0}, 128'd1);
    wait_done(1'b0, MEM_LAT, "post_rst_lat");
    @(negedge clk);

    // MEM_LAT=1 boundary on the second instance.
    l_req = 1'b1;
    @(negedge clk);
    check("lat1_gnt", {127'b0, l_gnt0}, 128'd1);
    check("lat1_nodone", {127'b0, l_done0}, 128'd0);
    @(negedge clk);
    check("lat1_done", {127'b0, l_done0}, 128'd1);
    check("lat1_rdata", l_rdata, 128'h00C0_FFEE);
    l_req = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
